// File: rtl/veririsc_pkg.sv
// Shared VeriRISC definitions: opcodes, default widths and the sequencer state encoding.
package veririsc_pkg;

  localparam int AWIDTH_DEF = 5;
  localparam int DWIDTH_DEF = 8;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/fetch_sequencer_counter.sv
// Loadable up-counter with enable and synchronous active-low reset.
// Load has priority over increment; the count wraps modulo 2^WIDTH.
module counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: load wins over increment, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = d;
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: RUN/HALTED machine, 8-phase instruction counter,
// program counter, instruction register and memory address mux.
module fetch_sequencer
  import veririsc_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] data,
  input  logic              ld_ir,
  input  logic              inc_pc,
  input  logic              ld_pc,
  input  logic              sel,
  input  logic              halt,
  input  logic              resume,
  output logic [2:0]        phase,
  output logic [2:0]        opcode,
  output logic [AWIDTH-1:0] ir_addr,
  output logic [AWIDTH-1:0] pc_addr,
  output logic [AWIDTH-1:0] addr,
  output logic              running
);

  state_e            state_q;
  state_e            state_d;
  logic [DWIDTH-1:0] ir_q;
  logic [DWIDTH-1:0] ir_d;
  logic              phase_en_s;
  logic              in_run_s;
  logic              pc_ld_s;
  logic              pc_en_s;

  assign in_run_s = (state_q == RUN);

  // Controller strobes act only in RUN, including the cycle that enters HALTED.
  assign pc_ld_s = in_run_s & ld_pc;
  assign pc_en_s = in_run_s & inc_pc;

  // Next state and phase advance: halt freezes the phase, resume steps it once.
  always_comb begin
    state_d    = state_q;
    phase_en_s = 1'b0;
    case (state_q)
      RUN: begin
        if (halt) begin
          state_d    = HALTED;
          phase_en_s = 1'b0;
        end else begin
          state_d    = RUN;
          phase_en_s = 1'b1;
        end
      end
      HALTED: begin
        if (resume) begin
          state_d    = RUN;
          phase_en_s = 1'b1;
        end else begin
          state_d    = HALTED;
          phase_en_s = 1'b0;
        end
      end
      default: begin
        state_d    = RUN;
        phase_en_s = 1'b0;
      end
    endcase
  end

  // Instruction register next value: capture the bus while running.
  always_comb begin
    ir_d = ir_q;
    if (in_run_s && ld_ir) begin
      ir_d = data;
    end else begin
      ir_d = ir_q;
    end
  end

  // State and instruction registers with synchronous reset to RUN / HLT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  counter #(.WIDTH(AWIDTH)) u_pc (
    .clk (clk),
    .rst (rst),
    .ld  (pc_ld_s),
    .en  (pc_en_s),
    .d   (ir_q[AWIDTH-1:0]),
    .q   (pc_addr)
  );

  counter #(.WIDTH(3)) u_phase (
    .clk (clk),
    .rst (rst),
    .ld  (1'b0),
    .en  (phase_en_s),
    .d   (3'd0),
    .q   (phase)
  );

  assign opcode  = ir_q[DWIDTH-1:DWIDTH-3];
  assign ir_addr = ir_q[AWIDTH-1:0];
  assign running = in_run_s;
  assign addr    = sel ? pc_addr : ir_addr;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter AWIDTH, default 5, sets the width of the address, PC and IR operand.
REQ-002 Parameter DWIDTH, default 8, sets the width of the memory data bus; the instruction is {opcode[2:0], operand[AWIDTH-1:0]}.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 data  input  DWIDTH  memory data bus, the instruction source.
REQ-006 ld_ir  input  1  from the controller; load the instruction register.
REQ-007 inc_pc  input  1  from the controller; increment the PC.
REQ-008 ld_pc  input  1  from the controller; load the PC from the IR operand.
REQ-009 sel  input  1  from the controller; 1 selects the PC as the memory address, 0 selects the IR operand.
REQ-010 halt  input  1  from the controller; stop the machine.
REQ-011 resume  input  1  restarts the machine from the halted state.
REQ-012 phase  output  3  current instruction phase, 0..7, fed to the controller.
REQ-013 opcode  output  3  IR[DWIDTH-1:DWIDTH-3], fed to the controller.
REQ-014 ir_addr  output  AWIDTH  IR operand field.
REQ-015 pc_addr  output  AWIDTH  current PC value.
REQ-016 addr  output  AWIDTH  memory address.
REQ-017 running  output  1  1 in state RUN, 0 in state HALTED.

Function
REQ-018 The block shall contain a two-state machine, RUN and HALTED.
REQ-019 In RUN, phase shall increment by 1 each cycle and wrap from 7 to 0.
REQ-020 In RUN with halt=1, the next state shall be HALTED and phase shall hold its current value.
REQ-021 In HALTED, phase, PC and IR shall hold their values, and ld_ir, inc_pc, ld_pc and halt shall be ignored.
REQ-022 In HALTED with resume=1, the next state shall be RUN and phase shall advance by 1 (wrapping 7 to 0).
REQ-023 resume shall be ignored in RUN; halt takes precedence in RUN.
REQ-024 IR shall load data on the next edge when ld_ir=1 in RUN; repeated loads in phases 2 and 3 are legal.
REQ-025 In RUN, ld_pc=1 shall load PC from ir_addr, taking priority over a simultaneous inc_pc.
REQ-026 In RUN, inc_pc=1 without ld_pc shall increment PC modulo 2^AWIDTH, wrapping 31 to 0 at the default width.
REQ-027 inc_pc and ld_pc asserted in the same cycle as a RUN-to-HALTED transition shall still take effect, so HLT leaves PC at the address of the next instruction.
REQ-028 addr shall be combinational: sel ? pc_addr : ir_addr.
REQ-029 opcode, ir_addr, pc_addr, phase and running shall be register outputs, with no combinational path from any input.

Reset
REQ-030 When rst=0 at a rising clk edge: state=RUN, phase=0, PC=0 and IR=0 (opcode HLT); running=1 from the next cycle.
REQ-031 Reset shall override all other inputs, including halt and resume, in any state and at any phase.

Structure
REQ-032 Shared package veririsc_pkg shall hold:
- opcode constants HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7;
- the AWIDTH and DWIDTH defaults;
- the RUN/HALTED state encoding.
REQ-033 The PC and the phase counter shall each be an instance of sub-module counter (parameterised width, load, enable, synchronous active-low reset); the remaining logic stays inline.

Verification
REQ-034 Reset check: rst=0 for one edge -> phase=0, pc_addr=0, opcode=0, running=1.
REQ-035 Free-run check: 9 edges with no controls asserted -> phase sequence 1,2,...,7,0,1.
REQ-036 IR load and address mux: data=8'hA7 with ld_ir=1 -> opcode=5, ir_addr=7; then sel=0 -> addr=7, and sel=1 with pc_addr=3 -> addr=3.
REQ-037 PC update and wrap:
- pc_addr=31 with inc_pc=1 -> pc_addr=0;
- ir_addr=5'h13 with ld_pc=1 and inc_pc=1 together -> pc_addr=5'h13.
REQ-038 Halt and resume, starting from pc_addr=3 at phase 4:
- halt=1 and inc_pc=1 -> running=0, phase stays 4, pc_addr=4;
- 3 more edges with inc_pc=1 -> pc_addr stays 4;
- resume=1 -> running=1, phase=5.
REQ-039 Reset while HALTED at phase 4 -> running=1, phase=0, pc_addr=0 on the next edge.
